// File: rtl/ped_button_frontend.sv
// Pedestrian push-button front end: sync, debounce, one-shot request,
// ack watch with a single retry, and post-request lockout per direction.
module ped_btn_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 16,
  parameter int LOCKOUT_CYCLES  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic ped_wait,
  output logic ped,
  output logic req_lamp,
  output logic no_ack
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);
  localparam logic [LW-1:0] LMAX = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    AWAIT_ACK,
    LOCKOUT
  } state_t;

  state_t          state, state_nx;
  logic            s1, s2, db, db_q;
  logic [DW-1:0]   cnt;
  logic [TW-1:0]   timer, timer_nx;
  logic [LW-1:0]   lock_cnt, lock_nx;
  logic            retry, retry_nx;
  logic            no_ack_nx;
  logic            press;

  assign press = db & ~db_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= btn_raw;
      s2   <= s1;
      db_q <= db;
      if (s2 != db) begin
        if (cnt == DMAX) begin
          db  <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      lock_cnt <= '0;
      retry    <= 1'b0;
      no_ack   <= 1'b0;
      ped      <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      lock_cnt <= lock_nx;
      retry    <= retry_nx;
      no_ack   <= no_ack_nx;
      ped      <= (state_nx == PULSE);
    end
  end

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    lock_nx   = '0;
    retry_nx  = retry;
    no_ack_nx = no_ack;
    unique case (state)
      IDLE: begin
        if (press && !ped_wait) state_nx = PULSE;
      end
      PULSE: begin
        state_nx = AWAIT_ACK;
        timer_nx = '0;
      end
      AWAIT_ACK: begin
        if (ped_wait) begin
          state_nx = LOCKOUT;
          retry_nx = 1'b0;
        end else if (timer == TMAX) begin
          if (!retry) begin
            state_nx = PULSE;
            retry_nx = 1'b1;
          end else begin
            state_nx  = LOCKOUT;
            no_ack_nx = 1'b1;
            retry_nx  = 1'b0;
          end
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      LOCKOUT: begin
        if (lock_cnt == LMAX) state_nx = IDLE;
        else lock_nx = lock_cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign req_lamp = (state == PULSE) | (state == AWAIT_ACK) | ped_wait;
endmodule

module ped_button_frontend #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 16,
  parameter int LOCKOUT_CYCLES  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_NS_raw,
  input  logic btn_EW_raw,
  input  logic ped_wait_NS,
  input  logic ped_wait_EW,
  output logic ped_NS,
  output logic ped_EW,
  output logic req_lamp_NS,
  output logic req_lamp_EW,
  output logic no_ack_NS,
  output logic no_ack_EW
);
  ped_btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACK_TIMEOUT    (ACK_TIMEOUT),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) u_ns (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_NS_raw),
    .ped_wait(ped_wait_NS),
    .ped     (ped_NS),
    .req_lamp(req_lamp_NS),
    .no_ack  (no_ack_NS)
  );

  ped_btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACK_TIMEOUT    (ACK_TIMEOUT),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) u_ew (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_EW_raw),
    .ped_wait(ped_wait_EW),
    .ped     (ped_EW),
    .req_lamp(req_lamp_EW),
    .no_ack  (no_ack_EW)
  );
endmodule

// File: tb/tb_ped_button_frontend.sv
// Bench for ped_button_frontend: expected pulse cycles are queued at
// stimulus time and matched against observed ped_* pulses.
module tb_ped_button_frontend;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_NS_raw = 1'b0;
  logic btn_EW_raw = 1'b0;
  logic ped_wait_NS = 1'b0;
  logic ped_wait_EW = 1'b0;
  logic ped_NS, ped_EW;
  logic req_lamp_NS, req_lamp_EW;
  logic no_ack_NS, no_ack_EW;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q_ns[$];
  int q_ew[$];

  ped_button_frontend dut (
    .clk        (clk),
    .rst        (rst),
    .btn_NS_raw (btn_NS_raw),
    .btn_EW_raw (btn_EW_raw),
    .ped_wait_NS(ped_wait_NS),
    .ped_wait_EW(ped_wait_EW),
    .ped_NS     (ped_NS),
    .ped_EW     (ped_EW),
    .req_lamp_NS(req_lamp_NS),
    .req_lamp_EW(req_lamp_EW),
    .no_ack_NS  (no_ack_NS),
    .no_ack_EW  (no_ack_EW)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every observed pulse must match the oldest queued cycle.
  always @(negedge clk) begin
    int e;
    if (ped_NS) begin
      checks++;
      if (q_ns.size() == 0) begin
        errors++;
        $display("FAIL ped_NS_pulse got cycle %0d expected none", cyc);
      end else begin
        e = q_ns.pop_front();
        if (cyc !== e) begin
          errors++;
          $display("FAIL ped_NS_pulse got cycle %0d expected %0d", cyc, e);
        end
      end
    end
    if (ped_EW) begin
      checks++;
      if (q_ew.size() == 0) begin
        errors++;
        $display("FAIL ped_EW_pulse got cycle %0d expected none", cyc);
      end else begin
        e = q_ew.pop_front();
        if (cyc !== e) begin
          errors++;
          $display("FAIL ped_EW_pulse got cycle %0d expected %0d", cyc, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    int c0;
    tick(2);
    checks++;
    if ({ped_NS, ped_EW, req_lamp_NS, req_lamp_EW, no_ack_NS, no_ack_EW}
        !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 000000",
               {ped_NS, ped_EW, req_lamp_NS, req_lamp_EW,
                no_ack_NS, no_ack_EW});
    end
    ped_wait_EW = 1'b1;
    #1;
    checks++;
    if (req_lamp_EW !== 1'b1) begin
      errors++;
      $display("FAIL reset_lamp_follow got %b expected 1", req_lamp_EW);
    end
    ped_wait_EW = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    c0 = cyc;
    btn_NS_raw = 1'b1;
    q_ns.push_back(c0 + 7);
    tick(9);
    checks++;
    if (req_lamp_NS !== 1'b1) begin
      errors++;
      $display("FAIL await_lamp got %b expected 1", req_lamp_NS);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ped_NS, req_lamp_NS, no_ack_NS, ped_EW, req_lamp_EW, no_ack_EW}
        !== 6'b0) begin
      errors++;
      $display("FAIL async_reset got %b expected 000000",
               {ped_NS, req_lamp_NS, no_ack_NS, ped_EW, req_lamp_EW,
                no_ack_EW});
    end
    @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
    q_ns.push_back(c0 + 7);
    tick(8);
    ped_wait_NS = 1'b1;
    tick(1);
    ped_wait_NS = 1'b0;
    btn_NS_raw = 1'b0;
    tick(30);
    checks++;
    if (q_ns.size() !== 0) begin
      errors++;
      $display("FAIL reset_held_press pending %0d expected 0", q_ns.size());
    end
  endtask

  task automatic test_basic;
    int c0;
    c0 = cyc;
    btn_NS_raw = 1'b1;
    q_ns.push_back(c0 + 7);
    tick(7);
    checks++;
    if (req_lamp_NS !== 1'b1) begin
      errors++;
      $display("FAIL basic_lamp_pulse got %b expected 1", req_lamp_NS);
    end
    tick(2);
    ped_wait_NS = 1'b1;
    tick(3);
    checks++;
    if ({req_lamp_NS, no_ack_NS} !== 2'b10) begin
      errors++;
      $display("FAIL basic_ack got %b expected 10",
               {req_lamp_NS, no_ack_NS});
    end
    btn_NS_raw = 1'b0;
    tick(5);
    ped_wait_NS = 1'b0;
    #1;
    checks++;
    if (req_lamp_NS !== 1'b0) begin
      errors++;
      $display("FAIL basic_lockout_lamp got %b expected 0", req_lamp_NS);
    end
    tick(30);
    checks++;
    if (q_ns.size() !== 0 || no_ack_NS !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_retry pending %0d no_ack %b expected 0 0",
               q_ns.size(), no_ack_NS);
    end
  endtask

  task automatic test_glitch;
    logic pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int c0;
    c0 = 0;
    for (int i = 0; i < 7; i++) begin
      btn_EW_raw = pat[i];
      if (i == 6) c0 = cyc;
      tick(1);
    end
    q_ew.push_back(c0 + 7);
    tick(7);
    ped_wait_EW = 1'b1;
    tick(1);
    ped_wait_EW = 1'b0;
    btn_EW_raw = 1'b0;
    tick(30);
    checks++;
    if (q_ew.size() !== 0) begin
      errors++;
      $display("FAIL glitch_pulse pending %0d expected 0", q_ew.size());
    end
  endtask

  task automatic test_noack;
    int c0;
    c0 = cyc;
    btn_NS_raw = 1'b1;
    q_ns.push_back(c0 + 7);
    q_ns.push_back(c0 + 24);
    tick(10);
    btn_NS_raw = 1'b0;
    tick(30);
    checks++;
    if (no_ack_NS !== 1'b0) begin
      errors++;
      $display("FAIL no_ack_early got %b expected 0", no_ack_NS);
    end
    tick(1);
    checks++;
    if (no_ack_NS !== 1'b1) begin
      errors++;
      $display("FAIL no_ack_set got %b expected 1", no_ack_NS);
    end
    tick(14);
    btn_NS_raw = 1'b1;
    q_ns.push_back(c0 + 62);
    tick(8);
    ped_wait_NS = 1'b1;
    btn_NS_raw = 1'b0;
    tick(3);
    ped_wait_NS = 1'b0;
    tick(30);
    checks++;
    if (q_ns.size() !== 0 || no_ack_NS !== 1'b1) begin
      errors++;
      $display("FAIL no_ack_sticky pending %0d no_ack %b expected 0 1",
               q_ns.size(), no_ack_NS);
    end
  endtask

  task automatic test_drop;
    int c0;
    ped_wait_EW = 1'b1;
    btn_EW_raw = 1'b1;
    tick(10);
    checks++;
    if (req_lamp_EW !== 1'b1) begin
      errors++;
      $display("FAIL drop_ew_lamp got %b expected 1", req_lamp_EW);
    end
    btn_EW_raw = 1'b0;
    tick(8);
    ped_wait_EW = 1'b0;
    tick(2);
    c0 = cyc;
    btn_NS_raw = 1'b1;
    q_ns.push_back(c0 + 7);
    tick(5);
    btn_NS_raw = 1'b0;
    tick(3);
    ped_wait_NS = 1'b1;
    tick(1);
    ped_wait_NS = 1'b0;
    tick(2);
    btn_NS_raw = 1'b1;
    tick(12);
    btn_NS_raw = 1'b0;
    tick(30);
    checks++;
    if (q_ns.size() !== 0 || q_ew.size() !== 0) begin
      errors++;
      $display("FAIL drop_pending ns %0d ew %0d expected 0 0",
               q_ns.size(), q_ew.size());
    end
  endtask

  task automatic test_back_to_back;
    int c0;
    c0 = cyc;
    btn_NS_raw = 1'b1;
    btn_EW_raw = 1'b1;
    q_ns.push_back(c0 + 7);
    q_ew.push_back(c0 + 7);
    tick(8);
    ped_wait_NS = 1'b1;
    ped_wait_EW = 1'b1;
    tick(1);
    ped_wait_NS = 1'b0;
    ped_wait_EW = 1'b0;
    tick(2);
    btn_NS_raw = 1'b0;
    btn_EW_raw = 1'b0;
    tick(30);
    checks++;
    if (q_ns.size() !== 0 || q_ew.size() !== 0) begin
      errors++;
      $display("FAIL simultaneous pending ns %0d ew %0d expected 0 0",
               q_ns.size(), q_ew.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_noack();
    test_drop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
